approx_err_monitor: RTL and testbench

- Error-statistics collector that sits directly downstream of the exact and approximate Dadda multipliers.
- Consumes pairs of products (exact, approx) through a valid/ready handshake over a window of NSAMP samples.
- Accumulates the error distance ED = |exact − approx|, the peak ED and the count of erroneous samples.
- Presents the window results behind a valid/ack handshake. Used to characterise each approximate Dadda configuration, in simulation and on FPGA.

---
 rtl/approx_err_monitor_if.sv | 44 ++++
 rtl/approx_err_monitor.sv | 134 +++++++++++++
 tb/tb_approx_err_monitor.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/approx_err_monitor_if.sv
// approx_err_monitor_if
//   Groups the sample handshake, window control and result signals of
//   approx_err_monitor. Clock and reset stay plain module ports.
//   master : stimulus/consumer side (drives start, pairs, res_ack)
//   slave  : the monitor itself
//   sum_sq is present only when ERR_SQ_EN is defined.
interface approx_err_monitor_if #(
  parameter int WIDTH = 8,
  parameter int NSAMP = 1024
);
  localparam int CNT_W = $clog2(NSAMP + 1);
  localparam int ACC_W = 2 * WIDTH + CNT_W;

  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic [2*WIDTH-1:0]   exact;
  logic [2*WIDTH-1:0]   approx;
  logic                 busy;
  logic                 res_valid;
  logic                 res_ack;
  logic [ACC_W-1:0]     sum_ed;
  logic [2*WIDTH-1:0]   max_ed;
  logic [CNT_W-1:0]     err_cnt;
`ifdef ERR_SQ_EN
  logic [2*ACC_W-1:0]   sum_sq;
`endif

  modport master (
    output start, in_valid, exact, approx, res_ack,
    input  in_ready, busy, res_valid, sum_ed, max_ed, err_cnt
`ifdef ERR_SQ_EN
    , input sum_sq
`endif
  );

  modport slave (
    input  start, in_valid, exact, approx, res_ack,
    output in_ready, busy, res_valid, sum_ed, max_ed, err_cnt
`ifdef ERR_SQ_EN
    , output sum_sq
`endif
  );
endinterface

// File: rtl/approx_err_monitor.sv
// approx_err_monitor
//   Collects error statistics between an exact and an approximate multiplier
//   over a window of NSAMP product pairs: sum of |exact-approx|, peak error
//   and number of erroneous samples. Results are presented behind a
//   res_valid/res_ack handshake.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : approx_err_monitor_if.slave (start, in_valid/in_ready, exact,
//           approx, busy, res_valid/res_ack, sum_ed, max_ed, err_cnt[, sum_sq])
// Optional feature macro: ERR_SQ_EN adds the sum of squared errors (sum_sq).
module approx_err_monitor #(
  parameter int WIDTH = 8,
  parameter int NSAMP = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  approx_err_monitor_if.slave  bus
);
  localparam int CNT_W = $clog2(NSAMP + 1);
  localparam int ACC_W = 2 * WIDTH + CNT_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

  state_t               state_q, state_d;
  logic                 in_ready, busy, res_valid;
  logic                 hs, last_hs, start_win;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   ed_p1;
  logic                 vld_p1;
  logic [ACC_W-1:0]     sum_ed_q;
  logic [2*WIDTH-1:0]   max_ed_q;
  logic [CNT_W-1:0]     err_cnt_q;
`ifdef ERR_SQ_EN
  logic [2*ACC_W-1:0]   sum_sq_q;
`endif

  function automatic logic [2*WIDTH-1:0] abs_diff(input logic [2*WIDTH-1:0] a,
                                                  input logic [2*WIDTH-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

`ifdef ERR_SQ_EN
  function automatic logic [4*WIDTH-1:0] square(input logic [2*WIDTH-1:0] d);
    logic [4*WIDTH-1:0] dx;
    dx = {{(2*WIDTH){1'b0}}, d};
    return dx * dx;
  endfunction
`endif

  assign hs        = bus.in_valid & in_ready;
  assign last_hs   = hs && (cnt_q == CNT_W'(NSAMP - 1));
  assign start_win = (state_q == IDLE) && bus.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b1;
    res_valid = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        if (last_hs) state_d = DRAIN;
      end
      DRAIN:  state_d = REPORT;
      REPORT: begin
        res_valid = 1'b1;
        if (bus.res_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt_q <= '0;
    else if (start_win) cnt_q <= '0;
    else if (hs)        cnt_q <= cnt_q + CNT_W'(1);
  end

  // Stage 1: error distance of the accepted pair
  always_ff @(posedge clk) begin
    if (hs) ed_p1 <= abs_diff(bus.exact, bus.approx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= hs;
  end

  // Stage 2: window accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_ed_q  <= '0;
      max_ed_q  <= '0;
      err_cnt_q <= '0;
`ifdef ERR_SQ_EN
      sum_sq_q  <= '0;
`endif
    end else if (start_win) begin
      sum_ed_q  <= '0;
      max_ed_q  <= '0;
      err_cnt_q <= '0;
`ifdef ERR_SQ_EN
      sum_sq_q  <= '0;
`endif
    end else if (vld_p1) begin
      sum_ed_q  <= sum_ed_q + ACC_W'(ed_p1);
      if (ed_p1 > max_ed_q) max_ed_q <= ed_p1;
      err_cnt_q <= err_cnt_q + CNT_W'(ed_p1 != '0);
`ifdef ERR_SQ_EN
      sum_sq_q  <= sum_sq_q + (2*ACC_W)'(square(ed_p1));
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = busy;
  assign bus.res_valid = res_valid;
  assign bus.sum_ed    = sum_ed_q;
  assign bus.max_ed    = max_ed_q;
  assign bus.err_cnt   = err_cnt_q;
`ifdef ERR_SQ_EN
  assign bus.sum_sq    = sum_sq_q;
`endif
endmodule

// File: tb/tb_approx_err_monitor.sv
// tb_approx_err_monitor
//   Directed bench for approx_err_monitor with NSAMP=4, WIDTH=8. A small
//   reference model accumulates the expected window statistics as pairs are
//   handshaked; the expected record is queued at the end of each window and
//   popped when the DUT reports.
`timescale 1ns/1ps
module tb_approx_err_monitor;
  localparam int WIDTH = 8;
  localparam int NSAMP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  approx_err_monitor_if #(.WIDTH(WIDTH), .NSAMP(NSAMP)) bus();
  approx_err_monitor #(.WIDTH(WIDTH), .NSAMP(NSAMP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    longint unsigned sum;
    longint unsigned mx;
    longint unsigned cnt;
    longint unsigned sq;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
  endtask

  task automatic model_add(input longint unsigned e, input longint unsigned a);
    longint unsigned ed;
    ed = (e >= a) ? e - a : a - e;
    m.sum += ed;
    if (ed > m.mx) m.mx = ed;
    if (ed != 0) m.cnt++;
    m.sq += ed * ed;
  endtask

  task automatic begin_window();
    m = '{0, 0, 0, 0};
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic send(input int e, input int a);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.exact    = 16'(e);
    bus.approx   = 16'(a);
    while (!bus.in_ready && guard < 50) begin
      step();
      guard++;
    end
    chk("in_ready_wait", 64'(guard < 50), 64'd1);
    step();
    bus.in_valid = 1'b0;
    model_add(longint'(e), longint'(a));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("gap_in_ready", 64'(bus.in_ready), 64'd1);
    end
  endtask

  // Called in the cycle right after the final handshake.
  task automatic collect(input int hold);
    exp_t e;
    int   guard;
    guard = 0;
    chk("drain_res_valid", 64'(bus.res_valid), 64'd0);
    chk("drain_in_ready",  64'(bus.in_ready),  64'd0);
    chk("drain_busy",      64'(bus.busy),      64'd1);
    step();
    chk("latency_res_valid", 64'(bus.res_valid), 64'd1);
    while (!bus.res_valid && guard < 20) begin
      step();
      guard++;
    end
    e = sb.pop_front();
    for (int i = 0; i <= hold; i++) begin
      chk("sum_ed",    64'(bus.sum_ed),    e.sum);
      chk("max_ed",    64'(bus.max_ed),    e.mx);
      chk("err_cnt",   64'(bus.err_cnt),   e.cnt);
`ifdef ERR_SQ_EN
      chk("sum_sq",    64'(bus.sum_sq),    e.sq);
`endif
      chk("report_res_valid", 64'(bus.res_valid), 64'd1);
      chk("report_in_ready",  64'(bus.in_ready),  64'd0);
      if (i < hold) step();
    end
    bus.res_ack = 1'b1;
    step();
    bus.res_ack = 1'b0;
    chk("ack_res_valid", 64'(bus.res_valid), 64'd0);
    chk("ack_busy",      64'(bus.busy),      64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({bus.in_ready, bus.busy, bus.res_valid}), 64'd0);
    chk({tag, "_res"},  64'({bus.sum_ed, bus.max_ed, bus.err_cnt}), 64'd0);
`ifdef ERR_SQ_EN
    chk({tag, "_sq"},   64'(bus.sum_sq), 64'd0);
`endif
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.exact    = '0;
    bus.approx   = '0;
    bus.res_ack  = 1'b0;

    // Reset, then 20 idle cycles without start
    repeat (3) step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check_all_zero("reset_idle");
    end

    // Zero-error window, back-to-back
    begin_window();
    for (int i = 0; i < 4; i++) send(1234, 1234);
    sb.push_back(m);
    collect(0);

    // Mixed errors, back-to-back
    begin_window();
    send(100, 96);
    send(50, 60);
    send(65025, 0);
    send(7, 7);
    sb.push_back(m);
    collect(0);

    // Mixed errors with gaps, extra pair offered after the window, long hold
    begin_window();
    idle_cycles(2);
    send(100, 96);
    idle_cycles(1);
    send(50, 60);
    idle_cycles(3);
    send(65025, 0);
    send(7, 7);
    sb.push_back(m);
    bus.in_valid = 1'b1;
    bus.exact    = 16'd999;
    bus.approx   = 16'd0;
    collect(10);
    bus.in_valid = 1'b0;

    // start pulsed during RUN must not restart the window
    begin_window();
    send(300, 200);
    send(10, 20);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start_in_run_busy",     64'(bus.busy),     64'd1);
    chk("start_in_run_in_ready", 64'(bus.in_ready), 64'd1);
    send(0, 5);
    send(40000, 40000);
    sb.push_back(m);
    collect(0);

    // Asynchronous reset after two samples discards the window
    begin_window();
    send(100, 96);
    send(50, 60);
    chk("partial_sum_ed", 64'(bus.sum_ed), 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    step();
    step();
    check_all_zero("reset_hold");
    rst_n = 1'b1;
    step();
    check_all_zero("after_reset");

    // Clean window after reset
    begin_window();
    send(100, 96);
    send(50, 60);
    send(65025, 0);
    send(7, 7);
    sb.push_back(m);
    collect(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
